// File: rtl/divider16bit_seq_pkg.sv
// rtl/divider16bit_seq_pkg.sv - shared types and constants for the sequential divider
// Purpose: FSM state encoding, default operand width and the quotient
//          reported for a zero divisor.
// Ports:   none (package)
package divider16bit_seq_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Zero-divisor quotient (all ones, DIVU semantics); the top replicates
  // bit 0 so any WIDTH gets an all-ones value.
  localparam logic [WIDTH_DEFAULT-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/divider16bit_seq_div_step.sv
// rtl/divider16bit_seq_div_step.sv - one restoring shift/trial-subtract/restore step
// Purpose: combinational single iteration of restoring division.
// Ports:   rem_i          current partial remainder (always < divisor_i)
//          dividend_msb_i next dividend bit shifted into the remainder
//          divisor_i      divisor
//          rem_o          partial remainder after this step
//          q_bit_o        quotient bit produced by this step
module div_step
  import divider16bit_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dividend_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The shifted remainder can need WIDTH+1 bits when the divisor has its
  // MSB set, so the trial subtraction is one bit wider than the operands.
  // Since rem_i < divisor_i, trial[WIDTH] is exactly the borrow.
  assign shifted = {rem_i, dividend_msb_i};
  assign trial   = shifted - {1'b0, divisor_i};

  assign q_bit_o = ~trial[WIDTH];
  // On borrow shifted < divisor, so its top bit is zero and can be dropped.
  assign rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/divider16bit_seq.sv
// rtl/divider16bit_seq.sv - sequential unsigned restoring divider, one bit per clock
// Purpose: divides A by B in STEPS cycles; zero divisor finishes in one cycle.
// Ports:   clk, rst (async, active-high)
//          start        request; accepted in IDLE or DONE
//          A, B         dividend / divisor, latched on accept
//          Q, R         registered quotient / remainder, held until next done
//          busy         high while a division is in progress
//          done         one-cycle pulse when Q/R/div_by_zero are updated
//          div_by_zero  set with done when B was zero, held with Q/R
module divider16bit_seq
  import divider16bit_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int STEPS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam logic [WIDTH-1:0] DIV0_Q = {WIDTH{DIV0_QUOTIENT[0]}};

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;   // dividend shifts out the top, quotient bits enter the bottom
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic             q_bit_d;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i         (rem_q),
    .dividend_msb_i(dvd_q[WIDTH-1]),
    .divisor_i     (dvs_q),
    .rem_o         (rem_d),
    .q_bit_o       (q_bit_d)
  );

  assign dvd_d = {dvd_q[WIDTH-2:0], q_bit_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= A;
            dvs_q   <= B;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (dvs_q == '0) begin
            // Zero divisor: report DIVU/REMU result one cycle after accept.
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            q_q     <= DIV0_Q;
            r_q     <= dvd_q;
            dbz_q   <= 1'b1;
          end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
              // Publish the final step directly so Q/R never show partial values.
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              q_q     <= dvd_d;
              r_q     <= rem_d;
              dbz_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider16bit_seq.sv
// tb/tb_divider16bit_seq.sv - self-checking bench for divider16bit_seq
module tb_divider16bit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A, B;
  logic [15:0] Q, R;
  logic        busy, done, div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  divider16bit_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A          (A),
    .B          (B),
    .Q          (Q),
    .R          (R),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: unsigned DIVU/REMU semantics.
  function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? 16'hFFFF : a / b;
  endfunction

  function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? a : a % b;
  endfunction

  // Drives one request and waits (bounded) for done; lat = edges after accept.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, output int lat,
                         output logic [15:0] q, output logic [15:0] r, output logic dz);
    @(negedge clk);
    start = 1'b1; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = Q; r = R; dz = div_by_zero;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; A = 16'd0; B = 16'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({Q, R, busy, done, div_by_zero} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: Q=%h R=%h busy=%b done=%b dbz=%b, all required 0", Q, R, busy, done, div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat, busy_cycles;
    lat = 0; busy_cycles = 0;
    // First accept on the first edge after reset release.
    start = 1'b1; A = 16'd100; B = 16'd7;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 16) begin n_fail++; $display("FAIL basic_latency: got %0d required 16", lat); end
    n_checks++;
    if (busy_cycles != 16) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d required 16", busy_cycles); end
    n_checks++;
    if ({Q, R, div_by_zero} !== {16'd14, 16'd2, 1'b0}) begin
      n_fail++; $display("FAIL basic_result: Q=%0d R=%0d dbz=%b required Q=14 R=2 dbz=0", Q, R, div_by_zero);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b required 0", busy); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: done=%b one cycle later, required 0", done); end
  endtask

  task automatic test_corners;
    logic [15:0] ta[4] = '{16'hFFFF, 16'd3, 16'hFFFF, 16'd9};
    logic [15:0] tb[4] = '{16'd1, 16'd10, 16'h8000, 16'd3};
    logic [15:0] eq[4] = '{16'hFFFF, 16'd0, 16'd1, 16'd3};
    logic [15:0] er[4] = '{16'd0, 16'd3, 16'h7FFF, 16'd0};
    int lat; logic [15:0] q, r; logic dz;
    for (int i = 0; i < 4; i++) begin
      run_div(ta[i], tb[i], lat, q, r, dz);
      n_checks++;
      if (lat != 16 || q !== eq[i] || r !== er[i] || dz !== 1'b0) begin
        n_fail++;
        $display("FAIL corner_%0d: %h/%h lat=%0d Q=%h R=%h dbz=%b required lat=16 Q=%h R=%h dbz=0",
                 i, ta[i], tb[i], lat, q, r, dz, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat; logic [15:0] q, r; logic dz;
    run_div(16'd5, 16'd0, lat, q, r, dz);
    n_checks++;
    if (lat != 1 || q !== 16'hFFFF || r !== 16'd5 || dz !== 1'b1) begin
      n_fail++;
      $display("FAIL div_zero: lat=%0d Q=%h R=%h dbz=%b required lat=1 Q=ffff R=0005 dbz=1", lat, q, r, dz);
    end
    @(negedge clk);
    n_checks++;
    if (div_by_zero !== 1'b1 || Q !== 16'hFFFF) begin
      n_fail++; $display("FAIL div_zero_hold: Q=%h dbz=%b required ffff/1", Q, div_by_zero);
    end
    run_div(16'd9, 16'd3, lat, q, r, dz);
    n_checks++;
    if (lat != 16 || q !== 16'd3 || r !== 16'd0 || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL div_zero_clear: lat=%0d Q=%0d R=%0d dbz=%b required lat=16 Q=3 R=0 dbz=0", lat, q, r, dz);
    end
  endtask

  task automatic test_start_in_run;
    int dones, done_at;
    logic [15:0] q, r;
    dones = 0; done_at = -1; q = 16'd0; r = 16'd0;
    @(negedge clk);
    start = 1'b1; A = 16'd50; B = 16'd6;
    for (int lat = 0; lat < 30; lat++) begin
      @(negedge clk);
      if (lat == 2) begin A = 16'd1; B = 16'd1; end
      if (lat == 14) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (done_at < 0) begin done_at = lat; q = Q; r = R; end
      end
    end
    n_checks++;
    if (dones != 1 || done_at != 16) begin
      n_fail++; $display("FAIL start_in_run_done: %0d pulses first at %0d, required 1 at 16", dones, done_at);
    end
    n_checks++;
    if (q !== 16'd8 || r !== 16'd2) begin
      n_fail++; $display("FAIL start_in_run_result: Q=%0d R=%0d required Q=8 R=2", q, r);
    end
  endtask

  task automatic test_reset_mid_run;
    int dones, lat; logic [15:0] q, r; logic dz;
    dones = 0;
    @(negedge clk);
    start = 1'b1; A = 16'd200; B = 16'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({Q, R, busy, done} !== 34'd0) begin
      n_fail++; $display("FAIL reset_mid_run: Q=%h R=%h busy=%b done=%b required all 0", Q, R, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL reset_no_done: %0d pulses required 0", dones); end
    run_div(16'd200, 16'd9, lat, q, r, dz);
    n_checks++;
    if (lat != 16 || q !== 16'd22 || r !== 16'd2) begin
      n_fail++; $display("FAIL reset_rerun: lat=%0d Q=%0d R=%0d required lat=16 Q=22 R=2", lat, q, r);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [15:0] q, r; logic dz;
    run_div(16'd77, 16'd5, lat, q, r, dz);
    n_checks++;
    if (lat != 16 || q !== 16'd15 || r !== 16'd2) begin
      n_fail++; $display("FAIL b2b_first: lat=%0d Q=%0d R=%0d required lat=16 Q=15 R=2", lat, q, r);
    end
    // Still in the done cycle: request the next division immediately.
    start = 1'b1; A = 16'd1000; B = 16'd33;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b required 1", busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 8) begin
        n_checks++;
        if (Q !== 16'd15 || R !== 16'd2) begin
          n_fail++; $display("FAIL b2b_hold: Q=%0d R=%0d mid-run, required held 15/2", Q, R);
        end
      end
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 16 || Q !== 16'd30 || R !== 16'd10) begin
      n_fail++; $display("FAIL b2b_second: lat=%0d Q=%0d R=%0d required lat=16 Q=30 R=10", lat, Q, R);
    end
  endtask

  task automatic test_random;
    int lat, exp_lat; logic [15:0] a, b, q, r; logic dz;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1:       b = 16'h8000 | 16'($urandom);
        2:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      exp_lat = (b == 16'd0) ? 1 : 16;
      run_div(a, b, lat, q, r, dz);
      n_checks++;
      if (lat != exp_lat || q !== ref_q(a, b) || r !== ref_r(a, b) || dz !== (b == 16'd0)) begin
        n_fail++;
        $display("FAIL random_%0d: %h/%h lat=%0d Q=%h R=%h dbz=%b required lat=%0d Q=%h R=%h dbz=%b",
                 i, a, b, lat, q, r, dz, exp_lat, ref_q(a, b), ref_r(a, b), b == 16'd0);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_corners;
    test_div_zero;
    test_start_in_run;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
